// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by the UART transmitter and receiver:
//            line-state encodings, oversampling constants and a 2-of-3
//            majority helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Line-state encodings. The transmitter uses the same values.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_START  = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'd15;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_sync
// Purpose  : SYNC_STAGES-deep flop chain that brings an asynchronous
//            single-bit input into the clk domain. Flops reset to 1 so that
//            an idle-high serial line does not show a false edge after reset.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            async_in - asynchronous input
//            sync_out - synchronised output
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_ff[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_module
// Purpose  : 8N1-style UART receiver with 16x oversampling. Detects the start
//            edge, verifies it at mid-bit, samples DATA_BITS data bits (LSB
//            first) and the stop bit at their centres, and reports each frame
//            with a one-clk rx_valid or frame_error strobe.
// Ports    : clk         - system clock
//            rst         - asynchronous active-high reset
//            baud_x16_en - one-clk strobe, 16 per bit period
//            rx_serial   - asynchronous serial input, idles high
//            rx_data     - last correctly framed byte
//            rx_valid    - one-clk pulse, rx_data updated
//            frame_error - one-clk pulse, stop bit sampled low
//            rx_active   - high while a frame is being received
// Options  : UART_RX_MAJORITY_EN - 2-of-3 majority vote around every sample
//            point; all strobes move one tick later.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_x16_en,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 rx_active
);

    localparam int         TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    // Decision is taken one tick after the centre, on the third vote sample.
    // The start check reloads the counter with 1 so that the centre of each
    // following bit still lines up with LAST_TICK.
    localparam logic [3:0] START_DECIDE = MID_START + 4'd1;
    localparam logic [3:0] BIT_DECIDE   = 4'd0;
    localparam logic [3:0] DATA_RELOAD  = 4'd1;
`else
    localparam logic [3:0] START_DECIDE = MID_START;
    localparam logic [3:0] BIT_DECIDE   = LAST_TICK;
    localparam logic [3:0] DATA_RELOAD  = 4'd0;
`endif

    logic                 rx_s;
    uart_state_t          state, state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [2:0]           bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n, active_n;
    logic                 sample;

    uart_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_serial),
        .sync_out (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] vote, vote_n;
    logic       vote_capture;

    // Capture the two samples preceding each decision tick.
    always_comb begin
        vote_capture = 1'b0;
        if (state == START) begin
            vote_capture = (tick_cnt == MID_START - 4'd1) || (tick_cnt == MID_START);
        end else if ((state == DATA) || (state == STOP)) begin
            vote_capture = (tick_cnt == LAST_TICK - 4'd1) || (tick_cnt == LAST_TICK);
        end
    end

    assign sample = majority3({vote[1:0], rx_s});
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_active   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            vote        <= '0;
`endif
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_idx     <= bit_n;
            shift_reg   <= shift_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_error <= ferr_n;
            rx_active   <= active_n;
`ifdef UART_RX_MAJORITY_EN
            vote        <= vote_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_idx;
        shift_n  = shift_reg;
        data_n   = rx_data;
        active_n = rx_active;
        // Strobes last exactly one clk, independent of the tick.
        valid_n  = 1'b0;
        ferr_n   = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        vote_n   = vote;
        if (baud_x16_en && vote_capture) begin
            vote_n = {vote[1:0], rx_s};
        end
`endif
        if (baud_x16_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tick_n   = '0;
                        active_n = 1'b1;
                        state_n  = START;
                    end
                end
                START: begin
                    if (tick_cnt == START_DECIDE) begin
                        if (sample) begin
                            // Line went back high before mid-bit: glitch.
                            active_n = 1'b0;
                            state_n  = IDLE;
                        end else begin
                            tick_n  = DATA_RELOAD;
                            state_n = DATA;
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == BIT_DECIDE) begin
                        // New bit enters at the MSB so the first bit ends at bit 0.
                        shift_n = {sample, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_n   = '0;
                            state_n = STOP;
                        end else begin
                            bit_n = bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == BIT_DECIDE) begin
                        if (sample) begin
                            data_n  = shift_reg;
                            valid_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                        // Returning at mid-stop leaves half a bit of margin
                        // for a back-to-back start edge.
                        active_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
                default: begin
                    active_n = 1'b0;
                    state_n  = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
